ua_receiver: RTL

- UART receive path; the counterpart to the team's UA transmitter. Same frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
- Samples the asynchronous serial input using an oversampling tick (`enable`) from the shared baud generator.
- Delivers received bytes with a valid/ack handshake and reports framing and overrun errors.
- Sits between the FPGA RX pin and the command/data consumer logic.

---
 rtl/ua_pkg.sv | 22 ++
 rtl/ua_rx_sync.sv | 43 ++++
 rtl/ua_receiver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ua_pkg.sv
// Shared types and constants for the UA serial receive path.
// State encoding and data width live here so they match the UA transmitter.
package ua_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } ua_state_e;

    localparam int   UA_DATA_BITS  = 8;
    localparam logic UA_IDLE_LEVEL = 1'b1;

    // Even parity: XOR of all data bits and the parity bit must be zero.
    function automatic logic ua_even_parity_ok(input logic [UA_DATA_BITS-1:0] data,
                                               input logic par);
        return ~((^data) ^ par);
    endfunction

endpackage

// File: rtl/ua_rx_sync.sv
// Two-flop synchronizer for the RX pin plus the tick-gated previous sample,
// giving the synchronized level and a start-edge (1 -> 0) detect.
module ua_rx_sync
    import ua_pkg::*;
(
    input  logic clk,
    input  logic rst_ff1,
    input  logic enable_i,
    input  logic ser_in_i,
    output logic rxs_o,
    output logic fall_o
);

    logic meta_q;
    logic rxs_q;
    logic rxs_prev_q;

    // Synchronizer chain; meta_q is only ever read by rxs_q.
    always_ff @(posedge clk or posedge rst_ff1) begin
        if (rst_ff1) begin
            meta_q <= UA_IDLE_LEVEL;
            rxs_q  <= UA_IDLE_LEVEL;
        end else begin
            meta_q <= ser_in_i;
            rxs_q  <= meta_q;
        end
    end

    // Previous synchronized sample, captured only on oversample ticks.
    always_ff @(posedge clk or posedge rst_ff1) begin
        if (rst_ff1) begin
            rxs_prev_q <= UA_IDLE_LEVEL;
        end else if (enable_i) begin
            rxs_prev_q <= rxs_q;
        end else begin
            rxs_prev_q <= rxs_prev_q;
        end
    end

    assign rxs_o  = rxs_q;
    assign fall_o = rxs_prev_q & ~rxs_q;

endmodule

// File: rtl/ua_receiver.sv
// UART receiver: 1 start, 8 data LSB first, 1 stop, oversampled by enable ticks.
// Optional even-parity bit and parity_err output when UA_RX_PARITY_EN is defined.
module ua_receiver
    import ua_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst_ff1,
    input  logic                    enable,
    input  logic                    ser_in,
    input  logic                    rx_ack,
    output logic [UA_DATA_BITS-1:0] dout_byte,
    output logic                    rx_valid,
    output logic                    dout_rdy,
    output logic                    frame_err,
    output logic                    overrun_err,
`ifdef UA_RX_PARITY_EN
    output logic                    parity_err,
`endif
    output logic                    rx_busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UA_DATA_BITS - 1);

    ua_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic [UA_DATA_BITS-1:0] shreg_q, shreg_d;
    logic [UA_DATA_BITS-1:0] dout_q, dout_d;
    logic                    valid_q, valid_d;
    logic                    rdy_q, rdy_d;
    logic                    ferr_q, ferr_d;
    logic                    oerr_q, oerr_d;
    logic                    busy_q, busy_d;
    logic                    rxs_s, fall_s, good_s, bad_stop_s;
`ifdef UA_RX_PARITY_EN
    logic                    perr_q, perr_d;
    logic                    par_bad_q, par_bad_d;
    logic                    par_fail_s;
`endif

    ua_rx_sync u_sync (
        .clk      (clk),
        .rst_ff1  (rst_ff1),
        .enable_i (enable),
        .ser_in_i (ser_in),
        .rxs_o    (rxs_s),
        .fall_o   (fall_s)
    );

    // Next-state logic; nothing moves unless an oversample tick is present.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        good_s     = 1'b0;
        bad_stop_s = 1'b0;
`ifdef UA_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        par_fail_s = 1'b0;
`endif
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = CNT_ZERO;
                    if (fall_s) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_d = CNT_ZERO;
                        if (rxs_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_DATA;
                            bit_idx_d = 3'd0;
`ifdef UA_RX_PARITY_EN
                            par_bad_d = 1'b0;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = CNT_ZERO;
                        shreg_d = {rxs_s, shreg_q[UA_DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_d = 3'd0;
`ifdef UA_RX_PARITY_EN
                            state_d   = ST_PARITY;
`else
                            state_d   = ST_STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`ifdef UA_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_STOP;
                        if (!ua_even_parity_ok(shreg_q, rxs_s)) begin
                            par_fail_s = 1'b1;
                            par_bad_d  = 1'b1;
                        end else begin
                            par_bad_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_IDLE;
                        if (rxs_s) begin
`ifdef UA_RX_PARITY_EN
                            good_s = ~par_bad_q;
`else
                            good_s = 1'b1;
`endif
                        end else begin
                            bad_stop_s = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output/handshake next values; a completing event wins over rx_ack.
    always_comb begin
        rdy_d   = good_s;
        dout_d  = good_s ? shreg_q : dout_q;
        valid_d = good_s ? 1'b1 : (rx_ack ? 1'b0 : valid_q);
        oerr_d  = (good_s && valid_q && !rx_ack) ? 1'b1 : (rx_ack ? 1'b0 : oerr_q);
        ferr_d  = bad_stop_s ? 1'b1 : (rx_ack ? 1'b0 : ferr_q);
        busy_d  = (state_d != ST_IDLE);
`ifdef UA_RX_PARITY_EN
        perr_d  = par_fail_s ? 1'b1 : (rx_ack ? 1'b0 : perr_q);
`endif
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst_ff1) begin
        if (rst_ff1) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shreg_q   <= {UA_DATA_BITS{1'b0}};
            dout_q    <= {UA_DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UA_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
            busy_q    <= busy_d;
`ifdef UA_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign dout_byte   = dout_q;
    assign rx_valid    = valid_q;
    assign dout_rdy    = rdy_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign rx_busy     = busy_q;
`ifdef UA_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule
